// File: rtl/uart_rx_hex_display.sv
// uart_rx_hex_display: 8N1-style UART receiver feeding a hex seven-segment history display.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   RX           asynchronous serial line, idle high
//   o_RX_DV      one-cycle pulse per accepted frame
//   o_RX_Byte    last accepted byte, LSB-aligned, bits >= DATA_BITS are 0
//   o_FRAME_ERR  sticky stop-bit-low flag, cleared by the next accepted frame
//   o_PARITY_ERR sticky parity mismatch flag, cleared by the next accepted frame
//   SEG          active-low segments, digit k at SEG[7k+6:7k], bit 0 = A .. bit 6 = G
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between data and stop.
// Without it o_PARITY_ERR stays 0 and PARITY_ODD has no effect.
module uart_rx_hex_display #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    RX,
  output logic                    o_RX_DV,
  output logic [7:0]              o_RX_Byte,
  output logic                    o_FRAME_ERR,
  output logic                    o_PARITY_ERR,
  output logic [7*NUM_DIGITS-1:0] SEG
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned HistW = 4 * NUM_DIGITS;

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                  r_state, w_state_nxt;
  logic                    r_rx_meta, r_rx_s;
  logic [CntW-1:0]         r_cnt;
  logic [2:0]              r_bit_idx;
  logic [7:0]              r_data;
  logic                    r_par_bad;
  logic                    r_dv, r_frame_err, r_parity_err;
  logic [7:0]              r_rx_byte;
  logic [HistW-1:0]        r_hist;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic [7*NUM_DIGITS-1:0] r_seg, w_seg;

  logic w_cnt_clr, w_bit_tick, w_bit_smp, w_par_smp, w_accept, w_ferr, w_perr, w_par_exp;
  logic [HistW+7:0]        w_hist_shift;
  logic [NUM_DIGITS+1:0]   w_valid_shift;

  assign w_bit_tick    = (r_cnt == CntW'(CLKS_PER_BIT - 1));
  assign w_par_exp     = (^r_data) ^ (PARITY_ODD != 0);
  assign w_hist_shift  = {r_hist, r_data};
  assign w_valid_shift = {r_valid, 2'b11};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nib);
    logic [6:0] seg;
    unique case (i_nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // RX synchroniser
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= StWaitIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_bit_smp   = 1'b0;
    w_par_smp   = 1'b0;
    w_accept    = 1'b0;
    w_ferr      = 1'b0;
    w_perr      = 1'b0;
    unique case (r_state)
      // Wait until the synchroniser has flushed its reset value (cnt reaches 2) so a line
      // held low through reset is never mistaken for idle.
      StWaitIdle: begin
        if (!r_rx_s) begin
          w_cnt_clr = 1'b1;
        end else if (r_cnt == CntW'(2)) begin
          w_state_nxt = StIdle;
        end
      end
      StIdle: begin
        w_cnt_clr = 1'b1;
        if (!r_rx_s) w_state_nxt = StStart;
      end
      StStart: begin
        if (r_cnt == CntW'(CLKS_PER_BIT / 2 - 1)) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = r_rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (w_bit_tick) begin
          w_cnt_clr = 1'b1;
          w_bit_smp = 1'b1;
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = StParity;
`else
            w_state_nxt = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (w_bit_tick) begin
          w_cnt_clr   = 1'b1;
          w_par_smp   = 1'b1;
          w_state_nxt = StStop;
        end
      end
`endif
      StStop: begin
        if (w_bit_tick) begin
          w_cnt_clr = 1'b1;
          if (!r_rx_s) begin
            w_ferr      = 1'b1;
            w_state_nxt = StWaitIdle;
          end else if (r_par_bad) begin
            w_perr      = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StWaitIdle;
    endcase
  end

  // Receive datapath
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_data       <= '0;
      r_par_bad    <= 1'b0;
      r_dv         <= 1'b0;
      r_rx_byte    <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_hist       <= '0;
      r_valid      <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      r_dv  <= w_accept;
      if (r_state == StIdle) begin
        r_bit_idx <= '0;
        r_data    <= '0;
        r_par_bad <= 1'b0;
      end
      if (w_bit_smp) begin
        r_data[r_bit_idx] <= r_rx_s;
        r_bit_idx         <= r_bit_idx + 3'd1;
      end
      if (w_par_smp) r_par_bad <= (r_rx_s != w_par_exp);
      if (w_ferr)    r_frame_err  <= 1'b1;
      if (w_perr)    r_parity_err <= 1'b1;
      if (w_accept) begin
        r_rx_byte    <= r_data;
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
        r_hist       <= w_hist_shift[HistW-1:0];
        r_valid      <= w_valid_shift[NUM_DIGITS-1:0];
      end
    end
  end

  // Registered decode: SEG follows the history one cycle later
  always_comb begin
    w_seg = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (r_valid[k]) w_seg[7*k +: 7] = hex_to_seg(r_hist[4*k +: 4]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_seg <= '1;
    else        r_seg <= w_seg;
  end

  assign o_RX_DV      = r_dv;
  assign o_RX_Byte    = r_rx_byte;
  assign o_FRAME_ERR  = r_frame_err;
  assign o_PARITY_ERR = r_parity_err;
  assign SEG          = r_seg;

endmodule

// File: tb/tb_uart_rx_hex_display.sv
module tb_uart_rx_hex_display;

  localparam int unsigned Cpb = 8;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RX;
  logic        o_RX_DV;
  logic [7:0]  o_RX_Byte;
  logic        o_FRAME_ERR;
  logic        o_PARITY_ERR;
  logic [27:0] SEG;

  uart_rx_hex_display #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (8),
    .NUM_DIGITS  (4),
    .PARITY_ODD  (0)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .RX          (RX),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte),
    .o_FRAME_ERR (o_FRAME_ERR),
    .o_PARITY_ERR(o_PARITY_ERR),
    .SEG         (SEG)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  b;
    logic [27:0] seg;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic        seg_pend = 1'b0;
  logic [27:0] seg_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each DV pulse, checks SEG on the following cycle
  always @(negedge CLK) begin
    if (seg_pend) begin
      seg_pend = 1'b0;
      check("seg_after_dv", 32'(SEG), 32'(seg_exp));
      check("dv_single_pulse", 32'(o_RX_DV), 32'd0);
    end else if (o_RX_DV === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_dv: got byte %0h expected no frame", o_RX_Byte);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rx_byte", 32'(o_RX_Byte), 32'(e.b));
        check("frame_err_at_dv", 32'(o_FRAME_ERR), 32'd0);
        check("parity_err_at_dv", 32'(o_PARITY_ERR), 32'd0);
        seg_exp  = e.seg;
        seg_pend = 1'b1;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic v);
    RX = v;
    wait_cyc(Cpb);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_v);
`endif
    send_bit(stop_v);
  endtask

  task automatic expect_frame(input logic [7:0] b, input logic [27:0] seg);
    exp_t e;
    e.b   = b;
    e.seg = seg;
    sb_q.push_back(e);
  endtask

  initial begin
    RX    = 1'b1;
    RST_N = 1'b0;
    wait_cyc(5);
    RST_N = 1'b1;
    wait_cyc(4);
    @(negedge CLK);
    check("reset_seg", 32'(SEG), 32'h0FFF_FFFF);
    check("reset_dv", 32'(o_RX_DV), 32'd0);
    check("reset_byte", 32'(o_RX_Byte), 32'd0);
    check("reset_ferr", 32'(o_FRAME_ERR), 32'd0);
    check("reset_perr", 32'(o_PARITY_ERR), 32'd0);
    wait_cyc(1);

    // Two back-to-back frames
    expect_frame(8'hA5, {7'h7F, 7'h7F, 7'h08, 7'h12});
    send_frame(8'hA5, 1'b1, 1'b0);
    expect_frame(8'h3C, {7'h08, 7'h12, 7'h30, 7'h46});
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_cyc(20);
    check("seg_a53c", 32'(SEG), 32'({7'h08, 7'h12, 7'h30, 7'h46}));

    // Short low glitch on an idle line
    RX = 1'b0;
    wait_cyc(3);
    RX = 1'b1;
    wait_cyc(30);
    check("glitch_ferr", 32'(o_FRAME_ERR), 32'd0);
    check("glitch_seg", 32'(SEG), 32'({7'h08, 7'h12, 7'h30, 7'h46}));

    // Stop bit low, then break, then a good frame
    send_frame(8'h55, 1'b0, 1'b0);
    wait_cyc(2);
    check("ferr_set", 32'(o_FRAME_ERR), 32'd1);
    check("ferr_seg_kept", 32'(SEG), 32'({7'h08, 7'h12, 7'h30, 7'h46}));
    wait_cyc(38);
    check("ferr_sticky", 32'(o_FRAME_ERR), 32'd1);
    RX = 1'b1;
    wait_cyc(16);
    expect_frame(8'h12, {7'h30, 7'h46, 7'h79, 7'h24});
    send_frame(8'h12, 1'b1, 1'b0);
    wait_cyc(20);
    check("ferr_cleared", 32'(o_FRAME_ERR), 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    wait_cyc(4);
    check("perr_set", 32'(o_PARITY_ERR), 32'd1);
    expect_frame(8'h07, {7'h79, 7'h24, 7'h40, 7'h78});
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cyc(20);
    check("perr_cleared", 32'(o_PARITY_ERR), 32'd0);
`endif

    // Reset during data bit 4 of 0xFF, line held low through release
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_cyc(4);
    RX    = 1'b0;
    RST_N = 1'b0;
    wait_cyc(3);
    check("midreset_seg", 32'(SEG), 32'h0FFF_FFFF);
    check("midreset_byte", 32'(o_RX_Byte), 32'd0);
    RST_N = 1'b1;
    wait_cyc(30);
    check("low_after_reset_seg", 32'(SEG), 32'h0FFF_FFFF);
    check("low_after_reset_ferr", 32'(o_FRAME_ERR), 32'd0);
    RX = 1'b1;
    wait_cyc(16);
    expect_frame(8'h01, {7'h7F, 7'h7F, 7'h40, 7'h79});
    send_frame(8'h01, 1'b1, 1'b1);
    wait_cyc(20);

    check("frames_outstanding", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx_hex_display.md
# uart_rx_hex_display

Parametrised UART receiver with a multi-digit hexadecimal seven-segment front end, the next generation of the board's serial-to-display path. It recovers 8N1-style frames from an asynchronous RX line with 2-FF synchronisation, start-bit glitch rejection and framing-error detection. Accepted bytes shift into a NUM_DIGITS-nibble history register, which drives active-low segment outputs. It sits between the board UART pin and the seven-segment headers and also exposes the byte stream for other consumers.

## Interface
- CLKS_PER_BIT, 217: clock cycles per bit, ≥ 4 (217 = 115200 baud at 25 MHz).
- DATA_BITS, 8: data bits per frame, 5..8.
- NUM_DIGITS, 2: displayed hex digits, even, 2..8.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Meaningful only with UART_RX_PARITY_EN.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RX  in  1  asynchronous serial line, idle high.
- o_RX_DV  out  1  one-cycle pulse per accepted frame.
- o_RX_Byte  out  8  last accepted data, LSB-aligned; bits ≥ DATA_BITS are 0.
- o_FRAME_ERR  out  1  sticky: stop bit sampled low. Cleared by the next accepted frame.
- o_PARITY_ERR  out  1  sticky parity mismatch. Cleared by the next accepted frame.
- SEG  out  7*NUM_DIGITS  active-low segments.
  - Digit k occupies SEG[7k+6:7k], with bit 0 = A … bit 6 = G.
  - Digit 0 is the least significant nibble of the newest byte.

## Operation
- RX passes through a 2-FF synchroniser; both flops reset to 1. All decisions use the synchronised value rx_s.
- FSM states: WAIT_IDLE, IDLE, START, DATA, PARITY (macro only), STOP.
- Reset enters WAIT_IDLE. WAIT_IDLE → IDLE when rx_s = 1. A line held low through reset is never taken as a start bit.
- IDLE → START on rx_s = 0; the bit counter clears.
- START: at count CLKS_PER_BIT/2 − 1 (integer division), sample rx_s.
  - rx_s = 0: go to DATA with count cleared.
  - rx_s = 1: glitch; return to IDLE with no flags changed.
- DATA: sample every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples. Then go to PARITY or STOP.
- PARITY: one sample. Mismatch against the XOR of the data bits (inverted when PARITY_ODD) marks the frame bad-parity.
- STOP: one sample.
  - rx_s = 1 and parity OK: frame accepted.
  - rx_s = 0: set o_FRAME_ERR, discard the frame, go to WAIT_IDLE (break/line-low tolerance).
  - Parity bad with stop high: set o_PARITY_ERR, discard, go to IDLE.
- Frame accepted:
  - o_RX_Byte loads; o_RX_DV pulses; both error flags clear.
  - History register shifts left by one byte: the new byte occupies digits 1:0 and the oldest byte drops out.
  - Digit-valid bits for those two digits set. Next state IDLE.
- Display:
  - A digit with its valid bit 0 is blank (all SEG bits 1).
  - A valid digit decodes hex, lit segments per value: 0 ABCDEF, 1 BC, 2 ABDEG, 3 ABCDG, 4 BCFG, 5 ACDFG, 6 ACDEFG, 7 ABC, 8 all, 9 ABCDFG, A ABCEFG, b CDEFG, C ADEF, d BCDEG, E ADEFG, F AEFG.
  - Lit segment = 0.
- For DATA_BITS < 8, the upper nibble shown carries zero-filled bits.

## Timing
- Reset values:
  - o_RX_DV = 0, o_RX_Byte = 0, o_FRAME_ERR = 0, o_PARITY_ERR = 0.
  - SEG all 1 (blank); history and valid bits 0.
  - Synchroniser flops = 1.
- RX-to-rx_s latency: 2 cycles.
- o_RX_DV and o_RX_Byte register on the edge after the stop-bit sample.
- SEG registers one cycle after o_RX_DV (registered decode).
- Error flags assert on the edge after the offending sample.
- Back-to-back frames are accepted. A start edge arriving immediately after the stop sample is detected from IDLE with no lost bits.
- RST_N assertion mid-frame aborts immediately. The partial frame is discarded and the display blanks.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state present; frames carry one parity bit between data and stop.
  - PARITY_ODD selects sense; o_PARITY_ERR is live.
- Undefined:
  - No PARITY state; frames are start + DATA_BITS + stop.
  - o_PARITY_ERR is tied 0 (port retained); PARITY_ODD is ignored.

## Test plan
- Reset release with RX high, CLKS_PER_BIT=8, NUM_DIGITS=4 -> SEG = 28'hFFFFFFF; outputs 0.
- Send 0xA5 -> one o_RX_DV pulse, o_RX_Byte=0xA5. Digit1 shows "A" (7'b0001000), digit0 shows "5" (7'b0010010), digits 3:2 blank. Send 0x3C -> digits show 3:A5… order "A53C".
- Low pulse of 3 cycles on an idle line -> no o_RX_DV, FSM back in IDLE, flags unchanged.
- Frame 0x55 with stop bit forced low -> o_FRAME_ERR=1, no o_RX_DV, display unchanged. RX held low 40 cycles then valid 0x12 -> accepted, o_FRAME_ERR=0.
- With UART_RX_PARITY_EN, PARITY_ODD=0, send 0x07 with parity bit 0 -> o_PARITY_ERR=1, no DV. Resend with parity bit 1 -> DV, flag cleared.
- RST_N low during data bit 4 of 0xFF, RX held low through release -> no frame; WAIT_IDLE holds until RX high. Next 0x01 is received correctly.
